// File: rtl/time_uart_reporter.sv
// Snapshots month/day/hour/min/sec on a request and sends "MM-DD HH:MM:SS\r\n" (or "...\n") as 8N1 UART.
// Optional macro TIME_UART_AUTO_REPORT_EN: also start a line whenever sec changes (one pending trigger held while busy).
module time_uart_reporter #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit CR_LF        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [3:0] month,
    input  logic [4:0] day,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_e;

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_CHR    = 4'd15;

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  chr_q, chr_d;
    logic [3:0]  mon_q, mon_d;
    logic [4:0]  day_q, day_d;
    logic [4:0]  hr_q, hr_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  sec_snap_q, sec_snap_d;
    logic [7:0]  cur_char;
    logic        start;

    function automatic logic [7:0] tens_asc(input logic [5:0] v);
        return 8'h30 + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] units_asc(input logic [5:0] v);
        return 8'h30 + 8'(v % 6'd10);
    endfunction

    function automatic logic [7:0] char_at(input logic [3:0] idx, input logic [5:0] mo,
                                           input logic [5:0] d, input logic [5:0] h,
                                           input logic [5:0] mi, input logic [5:0] s);
        case (idx)
            4'd0:    return tens_asc(mo);
            4'd1:    return units_asc(mo);
            4'd2:    return 8'h2D;
            4'd3:    return tens_asc(d);
            4'd4:    return units_asc(d);
            4'd5:    return 8'h20;
            4'd6:    return tens_asc(h);
            4'd7:    return units_asc(h);
            4'd8:    return 8'h3A;
            4'd9:    return tens_asc(mi);
            4'd10:   return units_asc(mi);
            4'd11:   return 8'h3A;
            4'd12:   return tens_asc(s);
            4'd13:   return units_asc(s);
            4'd14:   return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign cur_char = char_at(chr_q, 6'(mon_q), 6'(day_q), 6'(hr_q), min_q, sec_snap_q);

`ifdef TIME_UART_AUTO_REPORT_EN
    logic [5:0] sec_hist_q;
    logic       pend_q, pend_d;
    logic       trig;

    assign trig  = (sec != sec_hist_q);
    assign start = (state_q == IDLE) && (req || trig || pend_q);

    // Any trigger seen in IDLE starts a line at once, so pending only accumulates outside IDLE.
    always_comb begin
        pend_d = pend_q;
        if (state_q == IDLE) pend_d = 1'b0;
        else if (trig)       pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_hist_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            sec_hist_q <= sec;
            pend_q     <= pend_d;
        end
    end
`else
    assign start = (state_q == IDLE) && req;
`endif

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        chr_d      = chr_q;
        mon_d      = mon_q;
        day_d      = day_q;
        hr_d       = hr_q;
        min_d      = min_q;
        sec_snap_d = sec_snap_q;
        tx         = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START;
                    baud_d     = BAUD_RELOAD;
                    bit_d      = '0;
                    chr_d      = '0;
                    mon_d      = month;
                    day_d      = day;
                    hr_d       = hour;
                    min_d      = min;
                    sec_snap_d = sec;
                end
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DATA: begin
                tx   = cur_char[bit_q];
                busy = 1'b1;
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            STOP: begin
                busy = 1'b1;
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (chr_q == LAST_CHR) begin
                        state_d = DONE;
                    end else begin
                        state_d = START;
                        // Without CR the units-of-seconds digit is followed directly by LF.
                        if (!CR_LF && chr_q == 4'd13) chr_d = LAST_CHR;
                        else                          chr_d = chr_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            chr_q      <= '0;
            mon_q      <= '0;
            day_q      <= '0;
            hr_q       <= '0;
            min_q      <= '0;
            sec_snap_q <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            chr_q      <= chr_d;
            mon_q      <= mon_d;
            day_q      <= day_d;
            hr_q       <= hr_d;
            min_q      <= min_d;
            sec_snap_q <= sec_snap_d;
        end
    end

endmodule

// File: doc/time_uart_reporter.md
Name: time_uart_reporter

Overview:
Reads the current calendar time (month, day, hour, minute, second) from the time-keeping core and transmits it as a fixed 16-character ASCII line over UART, 8N1. It is the outbound counterpart of the UART time-load path: the load path writes time into the core, and this block reads the time back out to the host. All time fields are captured in one snapshot when a report starts, so a line never mixes values from before and after a carry.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
CR_LF, 1, 1 = line ends "\r\n" (16 chars); 0 = line ends "\n" only (15 chars).

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low (asserted at 0)
req  input  1  report request, sampled on rising clk edge
month  input  4  binary month, 1-12
day  input  5  binary day, 1-31
hour  input  5  binary hour, 0-23
min  input  6  binary minute, 0-59
sec  input  6  binary second, 0-59
tx  output  1  UART serial out, idle high
busy  output  1  high from the accept cycle until the last stop bit completes
done  output  1  one-cycle pulse after the last stop bit of a line

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, done=0, FSM=IDLE, all counters and the snapshot cleared. Reset asserted mid-frame aborts the line at once; tx goes high with no partial stop bit.
- Accept: in IDLE, if req=1 at a clk edge, capture all five fields into the snapshot register in that same edge, set busy=1, and enter START for character 0. req is level-sampled in IDLE only; req while busy is ignored, not queued.
- Line format: "MM-DD HH:MM:SS\r\n". Each field is two decimal ASCII digits with a leading zero: tens = v/10, units = v%10, char = 8'h30 + digit. Separators are '-' (2D), ' ' (20), ':' (3A), CR (0D), LF (0A). Character index 0..15; with CR_LF=0, CR is skipped (15 chars).
- Out-of-range inputs (for example hour=31 or min=63) are not clamped; they are converted arithmetically, giving "31" or "63".
- FSM states: IDLE -> START -> DATA -> STOP -> (next char ? START : DONE) -> IDLE.
  - START: tx=0 for exactly CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each bit held exactly CLKS_PER_BIT cycles.
  - STOP: tx=1 for exactly CLKS_PER_BIT cycles.
  - DONE: lasts 1 cycle; done=1 and busy=0 in that cycle (busy drops in the same cycle done rises).
- Timing: the start bit of char 0 appears on tx on the cycle after the accept edge. Characters are sent back to back with no idle gap. Total line length = 16*10*CLKS_PER_BIT cycles (15*10*CLKS_PER_BIT with CR_LF=0). From the accept edge to the done pulse is that many cycles plus 1.
- A req held high during DONE is not accepted; it is accepted in the following IDLE cycle.
- A new report may start on the cycle after DONE.
- The baud counter is a plain down-counter reloaded at each bit boundary, with no fractional correction.
- Field inputs may change at any time; only the snapshot taken at accept is transmitted.

Optional Feature:
Macro: TIME_UART_AUTO_REPORT_EN.
- Defined: the block registers sec (reset value 0) and raises an internal trigger whenever sec differs from its registered copy. The trigger is ORed with req. A trigger that arrives while busy is held pending (a single flag, not a count) and is accepted in the next IDLE cycle. The result is one line per second, with no host request needed.
- Not defined: reports start only on req. No sec history register or pending flag exists.

Test Plan:
1. CLKS_PER_BIT=4, CR_LF=1, month=8 day=17 hour=4 min=20 sec=5, one-cycle req -> tx decodes "08-17 04:20:05\r\n"; done pulses exactly 641 cycles after the accept edge; busy is high for 640 cycles.
2. During test 1, change sec to 6 and hour to 5 at char 3 -> the transmitted line is unchanged ("...04:20:05"); a second req after done sends "...05:20:06".
3. req pulsed again 50 cycles into a line -> ignored; exactly one line is output and done pulses once.
4. rst=0 while a data bit 0 is on tx -> tx=1 and busy=0 asynchronously, before the next clk edge; after release, tx stays idle until req.
5. CR_LF=0, month=12 day=31 hour=23 min=59 sec=59 -> "12-31 23:59:59\n" with 15 chars and done after 601 cycles.
6. With TIME_UART_AUTO_REPORT_EN defined, sec increments every 1000 cycles and CLKS_PER_BIT=4 -> one line per increment with no req. With sec stepping every 300 cycles, increments arriving mid-line set the pending flag, and each following line starts 1 cycle after the previous done.
